// File: rtl/nrz_framer.sv
// NRZ framer: alternating preamble, 16-bit sync word, then payload bytes MSB first, one bit per BAUD_DIV clocks.
// Optional macro NRZ_DIFF_ENC_EN switches DATA to differential encoding (DATA_k = DATA_(k-1) ^ bit_k).
module nrz_framer #(
   parameter int          BAUD_DIV     = 41667,
   parameter int          PREAMBLE_LEN = 16,
   parameter logic [15:0] SYNC_WORD    = 16'h1ACF
) (
   input  logic       CLK,
   input  logic       PB,
   input  logic       TX_START,
   input  logic [7:0] TX_LEN,
   input  logic [7:0] BYTE_IN,
   input  logic       BYTE_VALID,
   output logic       BYTE_READY,
   output logic       DATA,
   output logic       BIT_STB,
   output logic       BUSY,
   output logic       UNDERRUN
);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_SYNC, S_PAY} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_baud_cnt;
   logic [10:0] r_bit_cnt;
   logic [7:0]  r_len;
   logic [7:0]  r_byte_cnt;
   logic [7:0]  r_hold;
   logic        r_hold_full;
   logic [6:0]  r_shift;
   logic        r_underrun;
   logic        r_data;

   logic        w_busy;
   logic        w_start;
   logic        w_bit_end;
   logic        w_field_done;
   logic        w_boundary;
   logic        w_next_bit;
   logic        w_xfer;
   logic [10:0] w_next_idx;
   logic [3:0]  w_sync_idx;
   logic [7:0]  w_load_byte;

   // Handshake: a byte moves when BYTE_VALID and BYTE_READY are both 1 at a rising CLK edge.
   assign w_busy      = (r_state != S_IDLE);
   assign w_start     = (r_state == S_IDLE) && TX_START;
   assign w_bit_end   = w_busy && (r_baud_cnt == 16'(BAUD_DIV - 1));
   assign w_next_idx  = r_bit_cnt + 11'd1;
   assign w_sync_idx  = 4'd15 - w_next_idx[3:0];
   assign w_load_byte = r_hold_full ? r_hold : 8'h00;
   assign w_xfer      = BYTE_VALID && BYTE_READY;

   assign BUSY       = w_busy;
   assign BIT_STB    = w_busy && (r_baud_cnt == 16'd0);
   assign BYTE_READY = w_busy && !r_hold_full && (r_byte_cnt < r_len);
   assign DATA       = r_data;
   assign UNDERRUN   = r_underrun;

   always_comb begin
      w_state_nxt  = r_state;
      w_next_bit   = 1'b0;
      w_boundary   = 1'b0;
      w_field_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (TX_START) w_state_nxt = S_PRE;
         end
         S_PRE: begin
            if (w_bit_end) begin
               if (r_bit_cnt == 11'(PREAMBLE_LEN - 1)) begin
                  w_field_done = 1'b1;
                  w_state_nxt  = S_SYNC;
                  w_next_bit   = SYNC_WORD[15];
               end else begin
                  w_next_bit = ~w_next_idx[0];
               end
            end
         end
         S_SYNC: begin
            if (w_bit_end) begin
               if (r_bit_cnt == 11'd15) begin
                  w_field_done = 1'b1;
                  if (r_len != 8'd0) begin
                     w_state_nxt = S_PAY;
                     w_boundary  = 1'b1;
                     w_next_bit  = w_load_byte[7];
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_next_bit = SYNC_WORD[w_sync_idx];
               end
            end
         end
         S_PAY: begin
            if (w_bit_end) begin
               // Last payload bit index is 8*len-1, i.e. {len-1, 3'b111}.
               if (r_bit_cnt == {r_len - 8'd1, 3'b111}) begin
                  w_field_done = 1'b1;
                  w_state_nxt  = S_IDLE;
               end else if (w_next_idx[2:0] == 3'd0) begin
                  w_boundary = 1'b1;
                  w_next_bit = w_load_byte[7];
               end else begin
                  w_next_bit = r_shift[6];
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!PB) begin
         r_state     <= S_IDLE;
         r_baud_cnt  <= 16'd0;
         r_bit_cnt   <= 11'd0;
         r_len       <= 8'd0;
         r_byte_cnt  <= 8'd0;
         r_hold      <= 8'd0;
         r_hold_full <= 1'b0;
         r_shift     <= 7'd0;
         r_underrun  <= 1'b0;
         r_data      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_baud_cnt  <= 16'd0;
            r_bit_cnt   <= 11'd0;
            r_len       <= TX_LEN;
            r_byte_cnt  <= 8'd0;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
            r_data      <= 1'b1;
         end else if (w_busy) begin
            r_baud_cnt <= w_bit_end ? 16'd0 : r_baud_cnt + 16'd1;
            if (w_bit_end) begin
               r_bit_cnt <= w_field_done ? 11'd0 : w_next_idx;
`ifdef NRZ_DIFF_ENC_EN
               r_data <= (w_state_nxt == S_IDLE) ? 1'b0 : (r_data ^ w_next_bit);
`else
               r_data <= w_next_bit;
`endif
            end
            if (w_boundary) begin
               r_shift <= w_load_byte[6:0];
               if (!r_hold_full) r_underrun <= 1'b1;
            end else if (w_bit_end) begin
               r_shift <= {r_shift[5:0], 1'b0};
            end
            // A byte arriving on a boundary cycle is kept for the next boundary.
            if (w_boundary)  r_hold_full <= w_xfer;
            else if (w_xfer) r_hold_full <= 1'b1;
            if (w_bit_end && (w_state_nxt == S_IDLE)) r_hold_full <= 1'b0;
            if (w_xfer) r_hold <= BYTE_IN;
            r_byte_cnt <= r_byte_cnt + {7'd0, w_xfer};
         end
      end
   end

endmodule

// File: tb/tb_nrz_framer.sv
// Randomized bench for nrz_framer: frame-level reference model built from handshake timestamps.
module tb_nrz_framer;
  localparam int BD = 4;
  localparam int PL = 4;
  localparam logic [15:0] SW = 16'h1ACF;

  logic       CLK = 1'b0;
  logic       PB = 1'b0;
  logic       TX_START = 1'b0;
  logic [7:0] TX_LEN = 8'd0;
  logic [7:0] BYTE_IN = 8'd0;
  logic       BYTE_VALID = 1'b0;
  logic       BYTE_READY, DATA, BIT_STB, BUSY, UNDERRUN;

  int n_cmp = 0;
  int n_err = 0;

  // per-cycle samples of one frame, index 0 = cycle after the start edge
  logic q_busy[$];
  logic q_data[$];
  logic q_stb[$];
  logic q_und[$];
  logic q_rdy[$];
  int         xfer_edge[$];
  logic [7:0] xfer_byte[$];
  logic [7:0] offer[$];
  logic       exp_q[$];

  nrz_framer #(.BAUD_DIV(BD), .PREAMBLE_LEN(PL), .SYNC_WORD(SW)) dut (
    .CLK(CLK), .PB(PB), .TX_START(TX_START), .TX_LEN(TX_LEN),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .DATA(DATA), .BIT_STB(BIT_STB), .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, DATA, 0);
    check_eq({tag, "_stb"}, BIT_STB, 0);
    check_eq({tag, "_busy"}, BUSY, 0);
    check_eq({tag, "_ready"}, BYTE_READY, 0);
    check_eq({tag, "_underrun"}, UNDERRUN, 0);
  endtask

  task automatic drive_byte(input int mode, input int oi);
    BYTE_IN = (oi < offer.size()) ? offer[oi] : 8'($urandom_range(0, 255));
    case (mode)
      0:       BYTE_VALID = 1'b0;
      1:       BYTE_VALID = 1'b1;
      default: BYTE_VALID = ($urandom_range(0, 1) == 1);
    endcase
  endtask

  // mode: 0 = never valid, 1 = always valid, 2 = random valid
  task automatic run_frame(input int len, input int mode, input bit restart);
    int total_bits = PL + 16 + 8 * len;
    int total = total_bits * BD;
    int oi = 0;
    int s_end = -1;
    int n_s, n_hs, und_edge, b_edge, restart_at, st, n_stb, n_bad_rdy;
    logic [7:0] byt;
    logic [15:0] sw;
    logic lvl;

    q_busy.delete(); q_data.delete(); q_stb.delete(); q_und.delete(); q_rdy.delete();
    xfer_edge.delete(); xfer_byte.delete(); exp_q.delete();
    restart_at = $urandom_range(BD, total - BD);

    @(posedge CLK); #1;
    TX_START = 1'b1;
    TX_LEN = 8'(len);
    drive_byte(mode, oi);
    for (int k = 0; k < total + 20; k++) begin
      @(negedge CLK);
      if (k >= 1) begin
        q_busy.push_back(BUSY); q_data.push_back(DATA); q_stb.push_back(BIT_STB);
        q_und.push_back(UNDERRUN); q_rdy.push_back(BYTE_READY);
      end
      if (BYTE_VALID && BYTE_READY) begin
        xfer_edge.push_back(k);
        xfer_byte.push_back(BYTE_IN);
        oi++;
      end
      if (k >= 2 && !BUSY) begin
        s_end = k - 1;
        break;
      end
      @(posedge CLK); #1;
      TX_START = restart && (k == restart_at);
      TX_LEN = 8'($urandom_range(0, 255));
      drive_byte(mode, oi);
    end
    BYTE_VALID = 1'b0;

    // scoreboard: expected raw bit stream from the framing rules
    n_hs = xfer_edge.size();
    if (mode == 1) check_eq("hs_count", n_hs, len);
    else check_eq("hs_within_len", (n_hs <= len), 1);
    sw = SW;
    for (int i = 0; i < PL; i++) exp_q.push_back((i % 2) == 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(sw[15 - i]);
    und_edge = -1;
    for (int k = 0; k < len; k++) begin
      b_edge = (PL + 16 + 8 * k) * BD;
      if (xfer_edge.size() > 0 && xfer_edge[0] < b_edge) begin
        byt = xfer_byte.pop_front();
        void'(xfer_edge.pop_front());
      end else begin
        byt = 8'h00;
        if (und_edge < 0) und_edge = b_edge;
      end
      for (int b = 7; b >= 0; b--) exp_q.push_back(byt[b]);
    end
`ifdef NRZ_DIFF_ENC_EN
    lvl = 1'b0;
    foreach (exp_q[i]) begin
      lvl = lvl ^ exp_q[i];
      exp_q[i] = lvl;
    end
`else
    lvl = 1'b0;
`endif

    check_eq("busy_len", s_end, total);
    n_s = q_busy.size();
    for (int j = 0; j < exp_q.size(); j++) begin
      st = j * BD;
      if (st + BD - 1 >= n_s) begin
        check_eq($sformatf("bit%0d_sampled", j), 0, 1);
        break;
      end
      check_eq($sformatf("data_b%0d_first", j), q_data[st], exp_q[j]);
      check_eq($sformatf("data_b%0d_last", j), q_data[st + BD - 1], exp_q[j]);
      check_eq($sformatf("stb_b%0d", j), q_stb[st], 1);
      check_eq($sformatf("underrun_b%0d", j), q_und[st], (und_edge >= 0 && st >= und_edge));
    end
    n_stb = 0;
    n_bad_rdy = 0;
    for (int s = 0; s < n_s; s++) begin
      if (q_stb[s]) n_stb++;
      if (q_rdy[s] && !q_busy[s]) n_bad_rdy++;
    end
    check_eq("stb_count", n_stb, total_bits);
    check_eq("ready_when_idle", n_bad_rdy, 0);
    if (s_end >= 0) begin
      check_eq("end_data", q_data[s_end], 0);
      check_eq("end_underrun", q_und[s_end], (und_edge >= 0));
    end
  endtask

  initial begin
    int len, mode, n_rdy;
    PB = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("por");
    @(posedge CLK); #1;
    PB = 1'b1;

    // bytes offered while idle must not be taken
    BYTE_VALID = 1'b1;
    n_rdy = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BYTE_READY) n_rdy++;
    end
    check_eq("idle_ready", n_rdy, 0);
    BYTE_VALID = 1'b0;

    offer = {};
    run_frame(0, 1, 1'b0);
    offer = {8'hA5, 8'h3C};
    run_frame(2, 1, 1'b0);
    offer = {};
    run_frame(2, 0, 1'b0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("underrun_sticky", UNDERRUN, 1);
    check_eq("idle_busy", BUSY, 0);
    run_frame(1, 1, 1'b1);

    for (int it = 0; it < 6; it++) begin
      offer = {};
      len = $urandom_range(0, 5);
      mode = $urandom_range(1, 2);
      run_frame(len, mode, ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of a frame
    @(posedge CLK); #1;
    TX_START = 1'b1;
    TX_LEN = 8'd4;
    BYTE_VALID = 1'b1;
    @(posedge CLK); #1;
    TX_START = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    PB = 1'b0;
    @(negedge CLK);
    check_eq("pre_reset_busy", BUSY, 1);
    @(negedge CLK);
    check_all_zero("midreset");
    @(posedge CLK);
    @(posedge CLK); #1;
    PB = 1'b1;
    BYTE_VALID = 1'b0;
    @(negedge CLK);
    check_all_zero("after_reset");
    offer = {8'h5A};
    run_frame(1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
